sram_arbiter: RTL

Arbitrates the single external SRAM port (the ram_ctrl read/write/workdone interface) between three requesters: VGA frame fetch, camera frame store and UART frame dump. Runs in the 24 MHz pixel domain between the requesters and ram_ctrl. Fixed priority with starvation aging, one outstanding transaction at a time, and a workdone timeout so a hung access cannot lock the port.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_arb_pick.sv | 50 +++++
 rtl/sram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and requester indices for the SRAM arbiter
package sram_arb_pkg;

  localparam int NREQ     = 3;
  localparam int REQ_VGA  = 0;
  localparam int REQ_CAM  = 1;
  localparam int REQ_UART = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - starvation counters and fixed-priority winner selection
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            arb,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // VGA is top priority and never needs promotion, so it has no counter
  logic [CW-1:0]   cnt [REQ_CAM:NREQ-1];
  logic [NREQ-1:0] sat;
  logic [NREQ-1:0] pool;

  for (genvar i = REQ_CAM; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || !req[i]) begin
        cnt[i] <= '0;
      end else if (arb) begin
        if (winner[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CW'(STARVE_LIMIT)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat = '0;
    for (int i = REQ_CAM; i < NREQ; i++) begin
      sat[i] = req[i] && (cnt[i] == CW'(STARVE_LIMIT));
    end
  end

  // Saturated requesters pre-empt the normal pool; lowest set bit wins
  always_comb begin
    pool   = (|sat) ? sat : req;
    winner = pool & (~pool + NREQ'(1));
    valid  = |req;
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-outstanding SRAM port arbiter with aging and workdone timeout
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_done,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [NREQ-1:0] winner;
  logic            valid;
  logic [TW-1:0]   tcnt;
  logic            sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  sram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .arb    (state == IDLE),
    .winner (winner),
    .valid  (valid)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid) state_nx = ACCESS;
      ACCESS:  if (mem_done || tcnt == TW'(TIMEOUT)) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The registered mem_* outputs double as the transaction latches; gnt is the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tcnt      <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      busy <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (valid) begin
            gnt       <= winner;
            mem_read  <= !sel_we;
            mem_write <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            tcnt      <= '0;
          end
        end
        ACCESS: begin
          tcnt <= tcnt + 1'b1;
          if (mem_done) begin
            done <= gnt;
            if (mem_read) rdata <= mem_rdata;
          end else if (tcnt == TW'(TIMEOUT)) begin
            err <= gnt;
          end
          if (state_nx == RELEASE) begin
            gnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
